// File: rtl/z16_gpio.sv
// Memory-mapped LED/button block: LED register with set/clear aliases, debounced buttons, sticky edge flags.
// Define Z16_GPIO_IRQ_EN to add the IRQ mask register (address 5) and the o_irq output.
module z16_gpio #(
  parameter int N_LED           = 6,
  parameter int N_BTN           = 1,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [2:0]       i_addr,
  input  logic             i_wen,
  input  logic [15:0]      i_wdata,
  input  logic             i_ren,
  output logic [15:0]      o_rdata,
  input  logic [N_BTN-1:0] i_btn,
  output logic [N_LED-1:0] o_led,
  output logic [N_BTN-1:0] o_btn_level
`ifdef Z16_GPIO_IRQ_EN
  ,
  output logic             o_irq
`endif
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [N_LED-1:0] led_q, led_d;
  logic [N_BTN-1:0] sync1_q, sync2_q;
  logic [N_BTN-1:0] level_q, level_d;
  logic [N_BTN-1:0] pend_q, pend_d;
  logic [N_BTN-1:0] w1c;
  logic [15:0]      rdata_q, rdata_d, rd_val;
  logic             unused_wdata;

  assign unused_wdata = ^i_wdata;

  always_comb begin
    led_d = led_q;
    if (i_wen) begin
      case (i_addr)
        3'd0:    led_d = i_wdata[N_LED-1:0];
        3'd1:    led_d = led_q | i_wdata[N_LED-1:0];
        3'd2:    led_d = led_q & ~i_wdata[N_LED-1:0];
        default: led_d = led_q;
      endcase
    end
  end

  // Counter tracks consecutive cycles the synchronised input disagrees with
  // the accepted level; the cycle it would reach DEBOUNCE_CYCLES the level flips.
  for (genvar gi = 0; gi < N_BTN; gi++) begin : g_db
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lvl_d;

    always_comb begin
      cnt_d = '0;
      lvl_d = level_q[gi];
      if (sync2_q[gi] != level_q[gi]) begin
        if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) lvl_d = ~level_q[gi];
        else                                   cnt_d = cnt_q + CW'(1);
      end
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) cnt_q <= '0;
      else       cnt_q <= cnt_d;
    end

    assign level_d[gi] = lvl_d;
  end

  // A rising edge arriving with its own W1C keeps the flag set.
  assign w1c    = (i_wen && i_addr == 3'd4) ? i_wdata[N_BTN-1:0] : '0;
  assign pend_d = (pend_q & ~w1c) | (level_d & ~level_q);

`ifdef Z16_GPIO_IRQ_EN
  logic [N_BTN-1:0] mask_q, mask_d;
  logic             irq_q, irq_d;

  assign mask_d = (i_wen && i_addr == 3'd5) ? i_wdata[N_BTN-1:0] : mask_q;
  assign irq_d  = |(pend_q & mask_q);
  assign o_irq  = irq_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end
`endif

  always_comb begin
    rd_val = '0;
    case (i_addr)
      3'd0:    rd_val[N_LED-1:0] = led_q;
      3'd3:    rd_val[N_BTN-1:0] = level_q;
      3'd4:    rd_val[N_BTN-1:0] = pend_q;
`ifdef Z16_GPIO_IRQ_EN
      3'd5:    rd_val[N_BTN-1:0] = mask_q;
`endif
      default: rd_val = '0;
    endcase
  end

  assign rdata_d = i_ren ? rd_val : rdata_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      led_q   <= '0;
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      pend_q  <= '0;
      rdata_q <= '0;
    end else begin
      led_q   <= led_d;
      sync1_q <= i_btn;
      sync2_q <= sync1_q;
      level_q <= level_d;
      pend_q  <= pend_d;
      rdata_q <= rdata_d;
    end
  end

  assign o_led       = led_q;
  assign o_btn_level = level_q;
  assign o_rdata     = rdata_q;

endmodule

// File: tb/tb_z16_gpio.sv
// Bench for z16_gpio: register vector table, hand-built debounce/W1C/reset sequences,
// then random traffic checked every cycle against a history-window reference model.
module tb_z16_gpio;
  localparam int NL = 6;
  localparam int NB = 2;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          rst, wen, ren;
  logic [2:0]    addr;
  logic [15:0]   wdata, rdata;
  logic [NB-1:0] btn, lvl;
  logic [NL-1:0] led;
`ifdef Z16_GPIO_IRQ_EN
  logic          irq;
`endif

  always #5 clk = ~clk;

  z16_gpio #(.N_LED(NL), .N_BTN(NB), .DEBOUNCE_CYCLES(DB)) dut (
    .i_clk(clk), .i_rst(rst), .i_addr(addr), .i_wen(wen), .i_wdata(wdata),
    .i_ren(ren), .o_rdata(rdata), .i_btn(btn), .o_led(led), .o_btn_level(lvl)
`ifdef Z16_GPIO_IRQ_EN
    , .o_irq(irq)
`endif
  );

  int n_chk = 0;
  int n_pass = 0;

  // Reference state
  logic [NL-1:0] m_led;
  logic [NB-1:0] m_lvl, m_pend, m_mask;
  logic          m_irq;
  logic [15:0]   m_rdata;
  logic [NB-1:0] hist[$];   // raw button samples, one per clock edge
  logic [NB-1:0] sq[$];     // last DB synchronised samples since reset

  typedef struct packed {
    logic [2:0]  addr;
    logic        wen;
    logic [15:0] wdata;
    logic        ren;
    logic [5:0]  exp_led;
    logic [15:0] exp_rdata;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%04h, expected 0x%04h", name, act, exp);
  endtask

  function automatic logic [15:0] m_read(input logic [2:0] a);
    logic [15:0] v;
    v = '0;
    case (a)
      3'd0:    v[NL-1:0] = m_led;
      3'd3:    v[NB-1:0] = m_lvl;
      3'd4:    v[NB-1:0] = m_pend;
      3'd5:    v[NB-1:0] = m_mask;
      default: v = '0;
    endcase
    return v;
  endfunction

  // Level flips once the last DB synchronised samples (input two edges old) all disagree with it.
  task automatic model_edge();
    logic [NB-1:0] s, new_lvl, w1c;
    logic          all_diff;
    if (rst) begin
      m_led = '0; m_lvl = '0; m_pend = '0; m_mask = '0; m_irq = 1'b0; m_rdata = '0;
      hist.delete(); hist.push_back('0); sq.delete();
      return;
    end
    m_irq = |(m_pend & m_mask);
    if (ren) m_rdata = m_read(addr);
    s = (hist.size() >= 2) ? hist[hist.size()-2] : '0;
    hist.push_back(btn);
    if (hist.size() > 4) void'(hist.pop_front());
    sq.push_back(s);
    if (sq.size() > DB) void'(sq.pop_front());
    new_lvl = m_lvl;
    for (int b = 0; b < NB; b++) begin
      if (sq.size() == DB) begin
        all_diff = 1'b1;
        foreach (sq[k]) if (sq[k][b] == m_lvl[b]) all_diff = 1'b0;
        if (all_diff) new_lvl[b] = ~m_lvl[b];
      end
    end
    w1c = (wen && addr == 3'd4) ? wdata[NB-1:0] : '0;
    m_pend = (m_pend & ~w1c) | (new_lvl & ~m_lvl);
    m_lvl = new_lvl;
`ifdef Z16_GPIO_IRQ_EN
    if (wen && addr == 3'd5) m_mask = wdata[NB-1:0];
`endif
    if (wen) begin
      case (addr)
        3'd0:    m_led = wdata[NL-1:0];
        3'd1:    m_led = m_led | wdata[NL-1:0];
        3'd2:    m_led = m_led & ~wdata[NL-1:0];
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_led", 16'(led), 16'(m_led));
    chk("model_level", 16'(lvl), 16'(m_lvl));
    chk("model_rdata", rdata, m_rdata);
`ifdef Z16_GPIO_IRQ_EN
    chk("model_irq", 16'(irq), 16'(m_irq));
`endif
  endtask

  task automatic do_read(input logic [2:0] a);
    addr = a; ren = 1'b1; wen = 1'b0;
    tick();
    ren = 1'b0;
  endtask

  task automatic do_write(input logic [2:0] a, input logic [15:0] d);
    addr = a; wdata = d; wen = 1'b1; ren = 1'b0;
    tick();
    wen = 1'b0;
  endtask

  initial begin
    int rate;
    tbl[0]  = '{3'd0, 1'b1, 16'h002A, 1'b0, 6'h2A, 16'h0000};
    tbl[1]  = '{3'd0, 1'b0, 16'h0000, 1'b1, 6'h2A, 16'h002A};
    tbl[2]  = '{3'd1, 1'b1, 16'h0005, 1'b1, 6'h2F, 16'h0000};
    tbl[3]  = '{3'd0, 1'b0, 16'h0000, 1'b1, 6'h2F, 16'h002F};
    tbl[4]  = '{3'd2, 1'b1, 16'h0008, 1'b1, 6'h27, 16'h0000};
    tbl[5]  = '{3'd0, 1'b1, 16'hFFFF, 1'b1, 6'h3F, 16'h0027};
    tbl[6]  = '{3'd0, 1'b0, 16'h0000, 1'b1, 6'h3F, 16'h003F};
    tbl[7]  = '{3'd6, 1'b1, 16'h1234, 1'b1, 6'h3F, 16'h0000};
    tbl[8]  = '{3'd0, 1'b0, 16'h0000, 1'b1, 6'h3F, 16'h003F};
    tbl[9]  = '{3'd3, 1'b0, 16'h0000, 1'b0, 6'h3F, 16'h003F};
    tbl[10] = '{3'd5, 1'b0, 16'h0000, 1'b1, 6'h3F, 16'h0000};
    tbl[11] = '{3'd3, 1'b0, 16'h0000, 1'b1, 6'h3F, 16'h0000};
    tbl[12] = '{3'd2, 1'b1, 16'h003F, 1'b0, 6'h00, 16'h0000};
    tbl[13] = '{3'd7, 1'b1, 16'hFFFF, 1'b1, 6'h00, 16'h0000};

    rst = 1'b1; wen = 1'b0; ren = 1'b0; addr = '0; wdata = '0; btn = '0;
    repeat (3) tick();
    chk("reset_led", 16'(led), 16'h0000);
    chk("reset_rdata", rdata, 16'h0000);
    chk("reset_level", 16'(lvl), 16'h0000);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      addr = tbl[i].addr; wen = tbl[i].wen; wdata = tbl[i].wdata; ren = tbl[i].ren;
      tick();
      $display("vec %0d addr=%0d wen=%0b wdata=0x%04h ren=%0b -> led=0x%02h rdata=0x%04h",
               i, tbl[i].addr, tbl[i].wen, tbl[i].wdata, tbl[i].ren, led, rdata);
      chk($sformatf("vec%0d_led", i), 16'(led), 16'(tbl[i].exp_led));
      chk($sformatf("vec%0d_rdata", i), rdata, tbl[i].exp_rdata);
    end
    wen = 1'b0; ren = 1'b0;

    // Short glitch is ignored; a held press lands exactly 2+DB edges later.
    btn = 2'b01; repeat (3) tick();
    btn = 2'b00; repeat (8) tick();
    chk("glitch_level", 16'(lvl), 16'h0000);
    do_read(3'd4);
    chk("glitch_pending", rdata, 16'h0000);
    btn = 2'b01; repeat (5) tick();
    chk("press_edge5", 16'(lvl), 16'h0000);
    tick();
    chk("press_edge6", 16'(lvl), 16'h0001);
    do_read(3'd4);
    chk("press_pending", rdata, 16'h0001);
    $display("seq debounce: level=0x%0h", lvl);

    // Release keeps the sticky flag; a new rise coincident with W1C wins.
    btn = 2'b00; repeat (8) tick();
    chk("release_level", 16'(lvl), 16'h0000);
    do_read(3'd4);
    chk("release_sticky", rdata, 16'h0001);
    btn = 2'b01; repeat (5) tick();
    do_write(3'd4, 16'h0001);
    chk("collide_level", 16'(lvl), 16'h0001);
    do_read(3'd4);
    chk("collide_pending", rdata, 16'h0001);
    do_write(3'd4, 16'h0001);
    do_read(3'd4);
    chk("w1c_pending", rdata, 16'h0000);
    $display("seq w1c: pending=0x%04h", rdata);

    // Reset in the middle of a debounce count.
    do_write(3'd0, 16'h0015);
    do_read(3'd0);
    btn = 2'b00; repeat (8) tick();
    btn = 2'b01; repeat (5) tick();
    rst = 1'b1; tick();
    chk("midrst_led", 16'(led), 16'h0000);
    chk("midrst_rdata", rdata, 16'h0000);
    chk("midrst_level", 16'(lvl), 16'h0000);
    tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("postrst_edge5", 16'(lvl), 16'h0000);
    tick();
    chk("postrst_edge6", 16'(lvl), 16'h0001);
    do_read(3'd4);
    chk("postrst_pending", rdata, 16'h0001);
    $display("seq reset: level=0x%0h", lvl);

`ifdef Z16_GPIO_IRQ_EN
    do_write(3'd4, 16'h0003);
    do_write(3'd5, 16'h0002);
    btn = 2'b00; repeat (8) tick();
    btn = 2'b01; repeat (8) tick();
    chk("irq_masked", 16'(irq), 16'h0000);
    btn = 2'b11; repeat (6) tick();
    chk("irq_same_edge", 16'(irq), 16'h0000);
    tick();
    chk("irq_set", 16'(irq), 16'h0001);
    do_write(3'd4, 16'h0002);
    tick();
    chk("irq_cleared", 16'(irq), 16'h0000);
    $display("seq irq: irq=%0b", irq);
`endif

    rate = 4;
    for (int c = 0; c < 2000; c++) begin
      if (c % 200 == 0) rate = $urandom_range(2, 12);
      rst   = ($urandom_range(0, 299) == 0);
      wen   = ($urandom_range(0, 9) < 3);
      ren   = ($urandom_range(0, 9) < 5);
      addr  = 3'($urandom_range(0, 7));
      wdata = 16'($urandom);
      for (int b = 0; b < NB; b++)
        if ($urandom_range(0, rate) == 0) btn[b] = ~btn[b];
      tick();
      if (wen || ren || rst)
        $display("rnd %0d rst=%0b addr=%0d wen=%0b wdata=0x%04h ren=%0b -> rdata=0x%04h led=0x%02h lvl=0x%0h",
                 c, rst, addr, wen, wdata, ren, rdata, led, lvl);
    end
    rst = 1'b0; wen = 1'b0; ren = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
